// File: rtl/lfsr_stream_pkg.sv
// Shared LFSR definitions for the byte-stream generator and checker.
// 16-bit right-shifting LFSR, taps 0,2,3,5, byte = low 8 state bits.
package lfsr_stream_pkg;

  localparam int LFSR_W   = 16;
  localparam int SEED_LEN = 9;
  localparam int TAP_A    = 0;
  localparam int TAP_B    = 2;
  localparam int TAP_C    = 3;
  localparam int TAP_D    = 5;

  typedef enum logic {
    SEED,
    CHECK
  } chk_state_e;

  function automatic logic [LFSR_W-1:0] lfsr16_step(
    input logic [LFSR_W-1:0] s
  );
    logic fb;
    fb = s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D];
    return {fb, s[LFSR_W-1:1]};
  endfunction

  // Bounded loop so the advance stays synthesizable for n <= SEED_LEN.
  function automatic logic [LFSR_W-1:0] lfsr16_advance(
    input logic [LFSR_W-1:0] s,
    input int                n
  );
    logic [LFSR_W-1:0] r;
    r = s;
    for (int i = 0; i < SEED_LEN; i++) begin
      if (i < n) r = lfsr16_step(r);
    end
    return r;
  endfunction

endpackage

// File: rtl/lfsr16_seed_assembler.sv
// Rebuilds generator state s_0 from nine overlapping stream bytes.
// Restarts on overlap violation; rejects the all-zero stuck state.
module lfsr16_seed_assembler
  import lfsr_stream_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  input  logic              en,
  input  logic [7:0]        d,
  output logic              done,
  output logic [LFSR_W-1:0] seed
);

  logic [3:0]        cnt;
  logic [3:0]        cnt_n;
  logic [LFSR_W-1:0] acc;
  logic [LFSR_W-1:0] acc_n;
  logic [7:0]        prev;
  logic              overlap_ok;
  logic              last;

  // Next seed count/accumulator; the violating byte becomes byte 0.
  always_comb begin
    overlap_ok = (d[6:0] == prev[7:1]);
    last       = (cnt == 4'(SEED_LEN - 1));
    seed       = {d[7], acc[LFSR_W-2:0]};
    done       = en && last && overlap_ok && (seed != '0);
    cnt_n      = cnt;
    acc_n      = acc;
    if (restart) begin
      cnt_n = '0;
    end else if (en) begin
      if (cnt == '0 || !overlap_ok) begin
        cnt_n = 4'd1;
        acc_n = {8'h00, d};
      end else if (last) begin
        cnt_n = '0;
      end else begin
        cnt_n = cnt + 4'd1;
        acc_n = acc | (LFSR_W'(d[7]) << (cnt + 4'd7));
      end
    end
  end

  // Seed registers; prev holds the last accepted byte for overlap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      acc  <= '0;
      prev <= '0;
    end else begin
      cnt <= cnt_n;
      acc <= acc_n;
      if (en && !restart) prev <= d;
    end
  end

endmodule

// File: rtl/lfsr_stream_checker.sv
// Self-synchronising checker for the 16-bit LFSR byte stream.
// Locks after nine seed bytes, then predicts and checks each byte.
module lfsr_stream_checker
  import lfsr_stream_pkg::*;
#(
  parameter int LOSS_THRESH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        d_valid,
  input  logic [7:0]  d,
  input  logic        clear,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_count,
  output logic [31:0] byte_count
);

  chk_state_e        state;
  chk_state_e        state_n;
  logic [LFSR_W-1:0] pred;
  logic [LFSR_W-1:0] seed_val;
  logic [3:0]        consec;
  logic              seed_en;
  logic              seed_done;
  logic              chk_en;
  logic              miss;
  logic              loss;

  assign seed_en = d_valid && !clear && (state == SEED);
  assign chk_en  = d_valid && !clear && (state == CHECK);
  assign miss    = chk_en && (d != pred[7:0]);
  assign loss    = miss && (consec == 4'(LOSS_THRESH - 1));
  assign locked  = (state == CHECK);

  lfsr16_seed_assembler u_seed (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (clear),
    .en      (seed_en),
    .d       (d),
    .done    (seed_done),
    .seed    (seed_val)
  );

  // Lock on a complete seed; drop lock on a run of mismatches.
  always_comb begin
    state_n = state;
    unique case (1'b1)
      clear:     state_n = SEED;
      seed_done: state_n = CHECK;
      loss:      state_n = SEED;
      default:   state_n = state;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SEED;
    else        state <= state_n;
  end

  // Predictor, error strobe and saturating counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred       <= '0;
      consec     <= '0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
      byte_count <= '0;
    end else if (clear) begin
      consec     <= '0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
      byte_count <= '0;
    end else begin
      err_pulse <= miss;
      if (seed_done) pred <= lfsr16_advance(seed_val, SEED_LEN);
      else if (chk_en) pred <= lfsr16_step(pred);
      if (chk_en) begin
        if (byte_count != '1) byte_count <= byte_count + 32'd1;
        if (!miss)     consec <= '0;
        else if (loss) consec <= '0;
        else           consec <= consec + 4'd1;
      end
      if (miss && err_count != '1) err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Directed bench for lfsr_stream_checker.
// Local reference generator drives the stream; checks go through chk.
module tb_lfsr_stream_checker;

  logic        clk;
  logic        rst_n;
  logic        d_valid;
  logic [7:0]  d;
  logic        clear;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [31:0] byte_count;

  int          n_chk;
  int          n_fail;
  logic [15:0] gs;
  logic [31:0] exp_err;
  logic [31:0] exp_bc;
  logic [7:0]  b;
  logic        ever_locked;

  lfsr_stream_checker #(.LOSS_THRESH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .d_valid    (d_valid),
    .d          (d),
    .clear      (clear),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_count  (err_count),
    .byte_count (byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic gen(output logic [7:0] o);
    logic fb;
    o  = gs[7:0];
    fb = ^(gs & 16'h002D);
    gs = {fb, gs[15:1]};
  endtask

  task automatic send(
    input logic [7:0] v,
    input logic       vld,
    input logic       clr
  );
    d       = v;
    d_valid = vld;
    clear   = clr;
    @(posedge clk);
    #1;
    d_valid = 1'b0;
    clear   = 1'b0;
  endtask

  task automatic send_clean(input int n);
    logic [7:0] x;
    for (int i = 0; i < n; i++) begin
      gen(x);
      send(x, 1'b1, 1'b0);
    end
  endtask

  task automatic relock(input string tag);
    send_clean(8);
    chk({tag, "_pre"}, {31'd0, locked}, 32'd0);
    send_clean(1);
    chk({tag, "_lock"}, {31'd0, locked}, 32'd1);
  endtask

  task automatic inject_err(input string tag);
    logic [7:0] x;
    gen(x);
    send(x ^ 8'h10, 1'b1, 1'b0);
    chk({tag, "_pulse"}, {31'd0, err_pulse}, 32'd1);
  endtask

  initial begin
    logic [7:0] ref_b [10];
    n_chk   = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    d_valid = 1'b0;
    d       = '0;
    clear   = 1'b0;
    ref_b   = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h80};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_pulse", {31'd0, err_pulse}, 32'd0);
    chk("rst_errc", {16'd0, err_count}, 32'd0);
    chk("rst_bytec", byte_count, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reference generator sanity against hand-derived bytes.
    gs = 16'h0001;
    for (int i = 0; i < 10; i++) begin
      gen(b);
      chk("gen_ref", {24'd0, b}, {24'd0, ref_b[i]});
    end

    // Clean continuous stream.
    gs = 16'h0001;
    relock("clean");
    send_clean(500);
    chk("clean_errc", {16'd0, err_count}, 32'd0);
    chk("clean_bytec", byte_count, 32'd500);

    // Clear, then same stream with random gaps.
    send(8'h00, 1'b0, 1'b1);
    chk("clr_locked", {31'd0, locked}, 32'd0);
    chk("clr_bytec", byte_count, 32'd0);
    gs = 16'h0001;
    for (int i = 0; i < 59; i++) begin
      while ($urandom_range(1, 0) == 1) begin
        send(8'h5A, 1'b0, 1'b0);
        chk("gap_pulse", {31'd0, err_pulse}, 32'd0);
      end
      gen(b);
      send(b, 1'b1, 1'b0);
      if (i == 7) chk("gap_pre", {31'd0, locked}, 32'd0);
      if (i == 8) chk("gap_lock", {31'd0, locked}, 32'd1);
    end
    chk("gap_errc", {16'd0, err_count}, 32'd0);
    chk("gap_bytec", byte_count, 32'd50);

    // Single corrupted byte, 20th after this point.
    send_clean(19);
    inject_err("single");
    chk("single_errc", {16'd0, err_count}, 32'd1);
    chk("single_lock", {31'd0, locked}, 32'd1);
    send_clean(1);
    chk("single_next", {31'd0, err_pulse}, 32'd0);
    send_clean(9);
    chk("single_after", {16'd0, err_count}, 32'd1);
    chk("single_bytec", byte_count, 32'd80);

    // Four consecutive corrupted bytes drop lock.
    exp_err = 32'd1;
    for (int i = 0; i < 4; i++) begin
      inject_err("loss");
      exp_err++;
      chk("loss_lock", {31'd0, locked}, (i == 3) ? 32'd0 : 32'd1);
    end
    chk("loss_errc", {16'd0, err_count}, exp_err);
    exp_bc = byte_count;
    relock("relock");
    chk("relock_errc", {16'd0, err_count}, exp_err);
    send_clean(1);
    chk("relock_pulse", {31'd0, err_pulse}, 32'd0);
    chk("relock_bytec", byte_count, exp_bc + 32'd1);

    // All-zero stream never locks.
    send(8'h00, 1'b0, 1'b1);
    ever_locked = 1'b0;
    for (int i = 0; i < 100; i++) begin
      send(8'h00, 1'b1, 1'b0);
      if (locked) ever_locked = 1'b1;
    end
    chk("zero_lock", {31'd0, ever_locked}, 32'd0);
    chk("zero_errc", {16'd0, err_count}, 32'd0);
    chk("zero_bytec", byte_count, 32'd0);

    // Overlap violation at seed byte 5 delays lock.
    send(8'h00, 1'b0, 1'b1);
    gs = 16'hACE1;
    send_clean(5);
    gen(b);
    send(b ^ 8'h01, 1'b1, 1'b0);
    send_clean(7);
    chk("ovl_pre", {31'd0, locked}, 32'd0);
    send_clean(1);
    chk("ovl_lock", {31'd0, locked}, 32'd1);

    // clear mid-CHECK with err_count = 3.
    send(8'h00, 1'b0, 1'b1);
    gs = 16'h1234;
    relock("c3");
    for (int i = 0; i < 3; i++) begin
      inject_err("c3");
      send_clean(2);
    end
    chk("c3_errc", {16'd0, err_count}, 32'd3);
    gen(b);
    send(b, 1'b1, 1'b1);
    chk("clr_mid_lock", {31'd0, locked}, 32'd0);
    chk("clr_mid_errc", {16'd0, err_count}, 32'd0);
    chk("clr_mid_bytec", byte_count, 32'd0);
    relock("clr_re");

    // Asynchronous reset mid-CHECK with err_count = 3.
    for (int i = 0; i < 3; i++) begin
      inject_err("r3");
      send_clean(2);
    end
    chk("r3_errc", {16'd0, err_count}, 32'd3);
    rst_n = 1'b0;
    #1;
    chk("arst_lock", {31'd0, locked}, 32'd0);
    chk("arst_errc", {16'd0, err_count}, 32'd0);
    chk("arst_bytec", byte_count, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    relock("rst_re");
    send_clean(5);
    chk("rst_re_errc", {16'd0, err_count}, 32'd0);
    chk("rst_re_bytec", byte_count, 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_stream_checker.md
# lfsr_stream_checker

Receive-side companion to the team's 16-bit LFSR byte-stream generator (taps 0,2,3,5, right-shifting, byte = low 8 bits of state). Sits at the output of a unit under test whose latency is unknown. Self-synchronises to the incoming byte stream, then predicts and checks every subsequent byte, counting mismatches and declaring loss of lock. Intended as a reusable on-chip self-check for delay-line and pipeline exercises.

## Interface

- LOSS_THRESH, 4: consecutive mismatching bytes in CHECK that force a return to SEED (legal range 1–15).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- d_valid  input  1  d carries a stream byte this cycle; gaps are allowed.
- d  input  8  received stream byte.
- clear  input  1  synchronous: zero the counters and return to SEED.
- locked  output  1  checker is in CHECK state.
- err_pulse  output  1  one-cycle strobe per mismatching byte in CHECK.
- err_count  output  16  total mismatches since reset/clear; saturates at 0xFFFF.
- byte_count  output  32  bytes checked in CHECK since reset/clear; saturates.

## Operation

- Generator step: fb = s[0]^s[2]^s[3]^s[5]; s_next = {fb, s[15:1]}. Stream byte k = s_k[7:0].
- Consequences used for sync: byte_{k}[6:0] == byte_{k-1}[7:1]; byte_k[7] = s_0[7+k]. Bytes 0..8 fully determine s_0.
- States: SEED, CHECK.
- SEED: seed_cnt 0..8 counts accepted valid bytes.
  - byte 0 loads s_0[7:0]; byte k (1..8) loads s_0[7+k].
  - k ≥ 1: if d[6:0] != previous byte[7:1], the current byte restarts the seed as byte 0 (seed_cnt = 1).
  - After byte 8: if assembled s_0 == 0, restart seed (stuck state, never lock); else load predictor with s_9 (s_0 advanced 9 steps) and go to CHECK.
- CHECK, per valid byte:
  - compare d to predictor[7:0]; advance predictor one step regardless of outcome.
  - match: consec_err = 0; byte_count++.
  - mismatch: err_pulse, err_count++, byte_count++, consec_err++; when consec_err reaches LOSS_THRESH go to SEED with seed_cnt = 0; the byte is not used as a seed byte.
- clear: counters and consec_err zeroed, state SEED, seed_cnt = 0; priority over d_valid the same cycle.
- d_valid low: no state change, err_pulse low.
- Counter saturation: holds at all-ones, never wraps.

## Timing

- Reset values: locked 0, err_pulse 0, err_count 0, byte_count 0; state SEED, seed_cnt 0, predictor 0.
- All outputs registered; no combinational path from d/d_valid to outputs.
- locked rises on the clock edge that accepts the 9th valid seed byte; the 10th valid byte is the first checked.
- err_pulse and counter updates appear one edge after the byte is sampled.
- locked falls on the edge that accepts the LOSS_THRESH-th consecutive mismatch (err_pulse high that same cycle).
- Reset asserted mid-operation: all state returns to reset values immediately; re-lock needs 9 fresh valid bytes.

## Structure

- Package lfsr_stream_pkg: tap positions, LFSR_W = 16, SEED_LEN = 9, state enum {SEED, CHECK}, function lfsr16_step(s) and lfsr16_advance(s, n); shared with the generator.
- One sub-module is natural: lfsr16_seed_assembler (seed_cnt, overlap check, s_0 assembly, zero-state reject, done strobe). Predictor, compare and counters stay in the top.

## Test plan

- Clean stream from generator state 0x0001 (bytes 0x01, 0x00, 0x00, …), continuous d_valid -> locked=1 after 9th byte, 500 bytes later err_count=0, byte_count=500.
- Same stream with d_valid toggled randomly 50% -> identical lock point in valid-byte terms, err_count=0.
- Locked, byte 20 after lock XOR 0x10 -> single err_pulse, err_count=1, locked stays 1, following bytes match.
- Locked, 4 consecutive corrupted bytes -> locked=0 on the 4th, err_count=4; clean bytes then re-lock after exactly 9, err_count unchanged.
- Constant 0x00 stream for 100 bytes -> locked never asserts, counters stay 0; stream with overlap violation at seed byte 5 -> lock delayed to 9 bytes after the violation.
- clear and, separately, rst_n low mid-CHECK with err_count=3 -> counters 0, locked 0 next edge (immediately for rst_n), re-lock after 9 bytes.
